// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: ARM condition evaluation, fetch redirect, link write
// and a fixed-length flush window after every taken branch.
//
// Parameters:
//   ADDR_W      address / PC width
//   FLUSH_DEPTH flush cycles per taken branch (legal 1..4)
//   LINK_OFFSET added to the branch PC to form the link value
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   br_valid / br_ready   branch handshake at the resolve stage
//   br_is_bl              branch-with-link
//   br_cond               ARM condition field
//   br_pc, br_target      branch PC and computed target
//   flags_we, flags_in    ALU flag write {N,Z,C,V}
//   t_address, pc_target  redirect pulse and held redirect address
//   bl_we, bl_data        link write pulse and held link value
//   flush                 squash younger stages
//   nzcv                  current flag register
//
// Build option:
//   FLAG_BYPASS_EN  when defined, a branch arriving together with a flag write
//                   is evaluated against flags_in in the same cycle; when not
//                   defined, the branch is stalled one cycle and evaluated
//                   against the freshly written nzcv.

module branch_resolve_unit #(
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int LINK_OFFSET = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic              br_is_bl,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    output logic              t_address,
    output logic [ADDR_W-1:0] pc_target,
    output logic              bl_we,
    output logic [ADDR_W-1:0] bl_data,
    output logic              flush,
    output logic [3:0]        nzcv
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Counter holds the number of flush cycles still to come after the
    // current one; loaded with FLUSH_DEPTH-1 on entry to FLUSH.
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LINK_ADD = ADDR_W'(LINK_OFFSET);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_nzcv;
    logic               r_t_address;
    logic [ADDR_W-1:0]  r_pc_target;
    logic               r_bl_we;
    logic [ADDR_W-1:0]  r_bl_data;
    logic               r_flush;

    logic [3:0]         w_flags_eval;
    logic               w_cond_pass;
    logic               w_accept;
    logic               w_take;
    logic [ADDR_W-1:0]  w_link;

    // ARM condition decode against {N,Z,C,V}.
    function automatic logic cond_pass(
        input logic [3:0] c,
        input logic [3:0] f
    );
        logic n;
        logic z;
        logic cf;
        logic v;
        logic res;
        n   = f[3];
        z   = f[2];
        cf  = f[1];
        v   = f[0];
        res = 1'b0;
        unique case (c)
            4'h0: res = z;
            4'h1: res = !z;
            4'h2: res = cf;
            4'h3: res = !cf;
            4'h4: res = n;
            4'h5: res = !n;
            4'h6: res = v;
            4'h7: res = !v;
            4'h8: res = cf & !z;
            4'h9: res = !cf | z;
            4'hA: res = (n == v);
            4'hB: res = (n != v);
            4'hC: res = !z & (n == v);
            4'hD: res = z | (n != v);
            4'hE: res = 1'b1;
            4'hF: res = 1'b0;
        endcase
        return res;
    endfunction

`ifdef FLAG_BYPASS_EN
    // Same-cycle flag write is forwarded into the condition check.
    assign br_ready     = (r_state == ST_IDLE);
    assign w_flags_eval = flags_we ? flags_in : r_nzcv;
`else
    // A flag write holds off the branch for one cycle so it sees the
    // updated register instead.
    assign br_ready     = (r_state == ST_IDLE) && !flags_we;
    assign w_flags_eval = r_nzcv;
`endif

    assign w_cond_pass = cond_pass(br_cond, w_flags_eval);
    assign w_accept    = br_valid && br_ready;
    assign w_take      = w_accept && w_cond_pass;
    assign w_link      = br_pc + LINK_ADD;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_nzcv      <= 4'b0000;
            r_t_address <= 1'b0;
            r_pc_target <= '0;
            r_bl_we     <= 1'b0;
            r_bl_data   <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_t_address <= 1'b0;
            r_bl_we     <= 1'b0;
            if (flags_we) begin
                r_nzcv <= flags_in;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state     <= ST_FLUSH;
                        r_cnt       <= CNT_LOAD;
                        r_flush     <= 1'b1;
                        r_t_address <= 1'b1;
                        r_pc_target <= br_target;
                        r_bl_we     <= br_is_bl;
                        r_bl_data   <= w_link;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign t_address = r_t_address;
    assign pc_target = r_pc_target;
    assign bl_we     = r_bl_we;
    assign bl_data   = r_bl_data;
    assign flush     = r_flush;
    assign nzcv      = r_nzcv;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: condition table, directed
// corner sequences and randomized traffic against a reference model.

module tb_branch_resolve_unit;

    localparam int AW = 32;
    localparam int FD = 2;
    localparam int LO = 4;
`ifdef FLAG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          br_valid;
    logic          br_ready;
    logic          br_is_bl;
    logic [3:0]    br_cond;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] br_target;
    logic          flags_we;
    logic [3:0]    flags_in;
    logic          t_address;
    logic [AW-1:0] pc_target;
    logic          bl_we;
    logic [AW-1:0] bl_data;
    logic          flush;
    logic [3:0]    nzcv;

    branch_resolve_unit #(
        .ADDR_W(AW),
        .FLUSH_DEPTH(FD),
        .LINK_OFFSET(LO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .br_valid(br_valid),
        .br_ready(br_ready),
        .br_is_bl(br_is_bl),
        .br_cond(br_cond),
        .br_pc(br_pc),
        .br_target(br_target),
        .flags_we(flags_we),
        .flags_in(flags_in),
        .t_address(t_address),
        .pc_target(pc_target),
        .bl_we(bl_we),
        .bl_data(bl_data),
        .flush(flush),
        .nzcv(nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: flush cycles remaining plus held output values.
    int            m_left;
    logic [3:0]    m_nzcv;
    logic [AW-1:0] m_tgt;
    logic [AW-1:0] m_link;
    logic          m_t;
    logic          m_bl;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] f;
        logic       taken;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, want, $time);
        end
    endtask

    // Conditions come in complementary pairs: odd codes invert even ones.
    function automatic bit ref_taken(input logic [3:0] c,
                                     input logic [3:0] f);
        bit n;
        bit z;
        bit cc;
        bit v;
        bit base;
        n = f[3];
        z = f[2];
        cc = f[1];
        v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c == 4'hE);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit m_ready();
        return (m_left == 0) && (BYP || !flags_we);
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_nzcv = 4'b0;
        m_tgt  = '0;
        m_link = '0;
        m_t    = 1'b0;
        m_bl   = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] fl;
        bit tk;
        if (!reset_n) begin
            model_reset();
        end else begin
            fl = (BYP && flags_we) ? flags_in : m_nzcv;
            tk = br_valid && m_ready() && ref_taken(br_cond, fl);
            if (m_left > 0) m_left--;
            m_t  = tk;
            m_bl = tk && br_is_bl;
            if (tk) begin
                m_tgt  = br_target;
                m_link = br_pc + AW'(LO);
                m_left = FD;
            end
            if (flags_we) m_nzcv = flags_in;
        end
    endtask

    // One clock: check br_ready, advance model, check registered outputs.
    task automatic cycle();
        #1;
        chk("br_ready", br_ready, m_ready());
        model_edge();
        @(posedge clk);
        #1;
        chk("t_address", t_address, m_t);
        chk("pc_target", pc_target, m_tgt);
        chk("bl_we", bl_we, m_bl);
        chk("bl_data", bl_data, m_link);
        chk("flush", flush, m_left > 0);
        chk("nzcv", nzcv, m_nzcv);
    endtask

    task automatic quiet();
        reset_n  = 1'b1;
        br_valid = 1'b0;
        br_is_bl = 1'b0;
        flags_we = 1'b0;
    endtask

    task automatic drain();
        quiet();
        for (int i = 0; i < 8; i++) begin
            if (m_left == 0) break;
            cycle();
        end
        chk("drained", flush, 1'b0);
    endtask

    task automatic set_flags(input logic [3:0] f);
        quiet();
        flags_we = 1'b1;
        flags_in = f;
        cycle();
        flags_we = 1'b0;
    endtask

    task automatic branch(input logic [3:0] c, input logic [AW-1:0] pc,
                          input logic [AW-1:0] tgt, input logic bl);
        quiet();
        br_valid  = 1'b1;
        br_cond   = c;
        br_pc     = pc;
        br_target = tgt;
        br_is_bl  = bl;
        cycle();
        br_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int pulses;
    int at_i;

    initial begin
        tbl[0]  = '{4'h0, 4'b0100, 1'b1};
        tbl[1]  = '{4'h1, 4'b0100, 1'b0};
        tbl[2]  = '{4'h2, 4'b0010, 1'b1};
        tbl[3]  = '{4'h3, 4'b0010, 1'b0};
        tbl[4]  = '{4'h4, 4'b1000, 1'b1};
        tbl[5]  = '{4'h5, 4'b1000, 1'b0};
        tbl[6]  = '{4'h6, 4'b0001, 1'b1};
        tbl[7]  = '{4'h7, 4'b0001, 1'b0};
        tbl[8]  = '{4'h8, 4'b0010, 1'b1};
        tbl[9]  = '{4'h9, 4'b0110, 1'b1};
        tbl[10] = '{4'hA, 4'b1001, 1'b1};
        tbl[11] = '{4'hB, 4'b1000, 1'b1};
        tbl[12] = '{4'hC, 4'b0000, 1'b1};
        tbl[13] = '{4'hD, 4'b0001, 1'b1};
        tbl[14] = '{4'hE, 4'b0000, 1'b1};
        tbl[15] = '{4'hF, 4'b1111, 1'b0};

        quiet();
        reset_n   = 1'b0;
        br_cond   = 4'h0;
        br_pc     = '0;
        br_target = '0;
        flags_in  = 4'h0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        reset_n = 1'b0;
        cycle();
        chk("rst_flush", flush, 1'b0);
        chk("rst_nzcv", nzcv, 4'h0);
        chk("rst_pc_target", pc_target, 32'h0);
        quiet();

        // EQ taken with link
        set_flags(4'b0100);
        branch(4'h0, 32'h40, 32'h100, 1'b1);
        chk("eq_t_address", t_address, 1'b1);
        chk("eq_pc_target", pc_target, 32'h100);
        chk("eq_bl_we", bl_we, 1'b1);
        chk("eq_bl_data", bl_data, 32'h44);
        chk("eq_flush1", flush, 1'b1);
        cycle();
        chk("eq_flush2", flush, 1'b1);
        chk("eq_pulse_end", t_address, 1'b0);
        cycle();
        chk("eq_flush_end", flush, 1'b0);
        chk("eq_ready", br_ready, 1'b1);

        // EQ not taken
        set_flags(4'b0000);
        branch(4'h0, 32'h80, 32'h300, 1'b0);
        chk("ne_t_address", t_address, 1'b0);
        chk("ne_flush", flush, 1'b0);
        chk("ne_ready", br_ready, 1'b1);
        chk("ne_pc_hold", pc_target, 32'h100);

        // Hand table
        for (int i = 0; i < 16; i++) begin
            set_flags(tbl[i].f);
            branch(tbl[i].cond, 32'h1000 + i, 32'h2000 + i, 1'b0);
            chk("tbl_taken", t_address, tbl[i].taken);
            drain();
        end

        // Full sweep of cond x flags
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                set_flags(4'(f));
                branch(4'(c), 32'(c * 16 + f), 32'(f * 256 + c), 1'b1);
                chk("sweep_taken", t_address, ref_taken(4'(c), 4'(f)));
                drain();
            end
        end

        // br_valid held through FLUSH with a new target
        branch(4'hE, 32'h10, 32'h100, 1'b0);
        chk("hold_first", pc_target, 32'h100);
        br_valid  = 1'b1;
        br_target = 32'h200;
        pulses = 0;
        at_i = -1;
        for (int i = 0; i < FD + 1; i++) begin
            cycle();
            if (t_address === 1'b1) begin
                pulses++;
                at_i = i;
            end
        end
        br_valid = 1'b0;
        chk("hold_pulses", pulses, 1);
        chk("hold_when", at_i, FD);
        chk("hold_target", pc_target, 32'h200);
        drain();

        // Flag write coinciding with a branch
        set_flags(4'b0000);
        quiet();
        flags_we  = 1'b1;
        flags_in  = 4'b0100;
        br_valid  = 1'b1;
        br_cond   = 4'h0;
        br_target = 32'h500;
        br_pc     = 32'h50;
        #1;
        chk("byp_ready", br_ready, BYP);
        cycle();
        flags_we = 1'b0;
        if (BYP) begin
            chk("byp_taken", t_address, 1'b1);
            br_valid = 1'b0;
        end else begin
            chk("stall_taken", t_address, 1'b0);
            cycle();
            chk("stall_late", t_address, 1'b1);
            br_valid = 1'b0;
        end
        chk("byp_target", pc_target, 32'h500);
        drain();

        // Reset in first flush cycle
        set_flags(4'b1010);
        branch(4'hE, 32'h60, 32'h600, 1'b0);
        chk("rf_flush", flush, 1'b1);
        reset_n  = 1'b0;
        flags_we = 1'b1;
        flags_in = 4'hF;
        br_valid = 1'b1;
        cycle();
        chk("rf_flush_abort", flush, 1'b0);
        chk("rf_nzcv", nzcv, 4'h0);
        chk("rf_t_address", t_address, 1'b0);
        quiet();
        #1;
        chk("rf_ready", br_ready, 1'b1);

        // Link value wrap
        branch(4'hE, 32'hFFFF_FFFC, 32'h700, 1'b1);
        chk("wrap_bl_we", bl_we, 1'b1);
        chk("wrap_bl_data", bl_data, 32'h0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 39) != 0);
            br_valid  = ($urandom_range(0, 9) < 6);
            br_is_bl  = $urandom_range(0, 1) == 1;
            br_cond   = 4'($urandom_range(0, 15));
            br_pc     = $urandom;
            br_target = $urandom;
            flags_we  = ($urandom_range(0, 9) < 3);
            flags_in  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) br_pc = 32'hFFFF_FFFC;
            cycle();
        end
        quiet();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-low reset; no other clock or reset SHALL exist.
REQ-002 Parameters (name, default, meaning) SHALL be:
- ADDR_W, 32, address/PC width
- FLUSH_DEPTH, 2, flush cycles per taken branch, legal 1..4
- LINK_OFFSET, 4, added to branch PC for link value
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock
- reset_n, in, 1, synchronous active-low reset
- br_valid, in, 1, branch present at resolve stage
- br_ready, out, 1, unit accepts branch this cycle
- br_is_bl, in, 1, branch-with-link
- br_cond, in, 4, ARM condition field
- br_pc, in, ADDR_W, PC of branch
- br_target, in, ADDR_W, computed target address
- flags_we, in, 1, ALU writes NZCV this cycle
- flags_in, in, 4, new NZCV {N,Z,C,V}
- t_address, out, 1, one-cycle pulse: fetch redirects to pc_target
- pc_target, out, ADDR_W, redirect address
- bl_we, out, 1, one-cycle pulse: write link register
- bl_data, out, ADDR_W, link value
- flush, out, 1, squash younger pipeline stages
- nzcv, out, 4, current flag register

Function
REQ-004 Branch SHALL be accepted on a rising edge where br_valid && br_ready.
REQ-005 Condition SHALL evaluate: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 4'b1111 never taken.
REQ-006 States SHALL be IDLE and FLUSH; br_ready SHALL be low in FLUSH.
REQ-007 Accepted taken branch at cycle k: in cycle k+1, t_address=1, pc_target=br_target, bl_we=br_is_bl, bl_data=br_pc+LINK_OFFSET (mod 2^ADDR_W); state enters FLUSH.
REQ-008 flush SHALL be high cycles k+1..k+FLUSH_DEPTH inclusive; state SHALL return to IDLE at cycle k+FLUSH_DEPTH+1.
REQ-009 t_address and bl_we SHALL be single-cycle pulses; pc_target and bl_data SHALL hold their values until the next taken branch.
REQ-010 Accepted not-taken branch SHALL produce no pulse, no flush, and leave state IDLE with br_ready high.
REQ-011 nzcv SHALL take flags_in on every edge with flags_we high, in any state.
REQ-012 br_valid during FLUSH SHALL be ignored (not accepted, not queued); upstream holds it.
REQ-013 Link value arithmetic SHALL wrap silently at ADDR_W bits.

Reset
REQ-014 With reset_n low at an edge: state=IDLE, nzcv=0, t_address=0, bl_we=0, flush=0, pc_target=0, bl_data=0.
REQ-015 Reset during FLUSH SHALL abort the flush immediately; br_ready SHALL be high the cycle after reset deasserts.
REQ-016 Reset SHALL take priority over acceptance and flag writes in the same cycle.

Configuration
REQ-017 Macro FLAG_BYPASS_EN SHALL control same-cycle flag/branch interaction.
REQ-018 With FLAG_BYPASS_EN defined: if flags_we and br_valid coincide in IDLE, the condition SHALL evaluate against flags_in; br_ready = (state==IDLE).
REQ-019 Without FLAG_BYPASS_EN: br_ready = (state==IDLE) && !flags_we; the branch SHALL be accepted the next cycle against the updated nzcv (one-cycle stall).

Verification
REQ-020 Bench SHALL cover:
- nzcv=4'b0100, br_cond=0000 (EQ), br_target=0x100, br_is_bl=1, br_pc=0x40 -> next cycle t_address=1, pc_target=0x100, bl_we=1, bl_data=0x44; flush high 2 cycles.
- nzcv=4'b0000, br_cond=0000 -> no t_address, no flush, br_ready stays high.
- All 16 br_cond values x all 16 nzcv values -> taken matches REQ-005 table; 1111 never taken.
- br_valid held high during FLUSH with new target 0x200 -> ignored until IDLE, then accepted once.
- flags_we=1, flags_in=4'b0100, br_cond=EQ same cycle -> with FLAG_BYPASS_EN taken next cycle; without, br_ready=0 one cycle, taken one cycle later.
- reset_n low in first FLUSH cycle -> flush=0, nzcv=0 next cycle, br_ready=1 after release; br_pc=0xFFFFFFFC, BL taken -> bl_data=0x00000000.
